operand_fetch: RTL

- SPU register-fetch stage that sits directly upstream of the Execute stage and feeds its RA/RB/RC/opcode/control inputs.
- Decodes a 32-bit instruction and reads up to three 128-bit operands from the 128 x 128-bit unified register file.
- Resolves read-after-write hazards by forwarding from Execute and from writeback.
- Registers everything into the RF/EX pipeline register.

---
 rtl/spu_pkg.sv | 60 ++++++
 rtl/spu_regfile.sv | 41 ++++
 rtl/operand_fetch.sv | 110 +++++++++++
 3 files changed

// File: rtl/spu_pkg.sv
// Shared definitions for the SPU operand fetch stage.
//   - Datapath and register address widths
//   - RRR-format opcode prefixes and the format test
//   - control_EX bit positions
//   - RF/EX pipeline record
//   - Operand source selection (Execute forward, writeback bypass, array)
package spu_pkg;

  localparam int NUM_REGS   = 128;
  localparam int DATA_W     = 128;
  localparam int REG_ADDR_W = 7;
  localparam int INSTR_W    = 32;
  localparam int OPCODE_W   = 11;
  localparam int CTRL_W     = 4;

  // Four-bit opcode prefixes that select the RRR (three-source) format.
  localparam logic [3:0] OP_RRR_1000 = 4'b1000;
  localparam logic [3:0] OP_RRR_1011 = 4'b1011;
  localparam logic [3:0] OP_RRR_1100 = 4'b1100;
  localparam logic [3:0] OP_RRR_1101 = 4'b1101;
  localparam logic [3:0] OP_RRR_1110 = 4'b1110;
  localparam logic [3:0] OP_RRR_1111 = 4'b1111;

  // control_EX bit positions; bits [1:0] are currently always zero.
  localparam int CTRL_RRR   = 3;
  localparam int CTRL_WR_RT = 2;

  typedef struct packed {
    logic                  valid;
    logic [OPCODE_W-1:0]   opcode;
    logic [CTRL_W-1:0]     control;
    logic [REG_ADDR_W-1:0] addr_rt;
    logic [DATA_W-1:0]     ra;
    logic [DATA_W-1:0]     rb;
    logic [DATA_W-1:0]     rc;
  } rfex_t;

  function automatic logic is_rrr(input logic [3:0] prefix);
    return (prefix == OP_RRR_1000) || (prefix == OP_RRR_1011) ||
           (prefix == OP_RRR_1100) || (prefix == OP_RRR_1101) ||
           (prefix == OP_RRR_1110) || (prefix == OP_RRR_1111);
  endfunction

  // Execute result is younger than writeback data, so it is checked first.
  function automatic logic [DATA_W-1:0] select_operand(
    input logic [REG_ADDR_W-1:0] src,
    input logic [DATA_W-1:0]     rf_data,
    input logic                  we_ex,
    input logic [REG_ADDR_W-1:0] addr_ex,
    input logic [DATA_W-1:0]     data_ex,
    input logic                  we_wb,
    input logic [REG_ADDR_W-1:0] addr_wb,
    input logic [DATA_W-1:0]     data_wb
  );
    if (we_ex && (addr_ex == src)) return data_ex;
    if (we_wb && (addr_wb == src)) return data_wb;
    return rf_data;
  endfunction

endpackage

// File: rtl/spu_regfile.sv
// Unified SPU register file: NUM_REGS x DATA_W, one write port, three
// asynchronous read ports. Synchronous active-high reset clears every entry.
// Ports:
//   clk, reset                  - clock and synchronous reset
//   wr_en, wr_addr, wr_data     - write port, captured at the rising edge
//   rd_addr_a/b/c, rd_data_a/b/c - combinational read ports
module spu_regfile #(
  parameter int NUM_REGS = 128,
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [ADDR_W-1:0] rd_addr_c,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] rd_data_c
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];
  assign rd_data_c = mem[rd_addr_c];

endmodule

// File: rtl/operand_fetch.sv
// SPU register-fetch stage. Decodes the instruction in ID, reads up to three
// operands with forwarding from Execute and writeback, and registers the
// result into the RF/EX pipeline register.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   stall, flush        - hold / squash the RF/EX register (flush wins)
//   valid_ID, instr_ID  - incoming instruction
//   regWr_EX, addrRT_EX, result_EX      - Execute-stage forward source
//   regWr_WB, addrRT_WB, writeData_WB   - writeback port (also bypassed)
//   readDataRA/RB/RC_EX, opcode, control_EX, addrRT_out, valid_EX - to EX
module operand_fetch
  import spu_pkg::*;
#(
  parameter int NUM_REGS = 128,
  parameter int DATA_W   = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_ID,
  input  logic [INSTR_W-1:0]    instr_ID,
  input  logic                  regWr_EX,
  input  logic [REG_ADDR_W-1:0] addrRT_EX,
  input  logic [DATA_W-1:0]     result_EX,
  input  logic                  regWr_WB,
  input  logic [REG_ADDR_W-1:0] addrRT_WB,
  input  logic [DATA_W-1:0]     writeData_WB,
  output logic [DATA_W-1:0]     readDataRA_EX,
  output logic [DATA_W-1:0]     readDataRB_EX,
  output logic [DATA_W-1:0]     readDataRC_EX,
  output logic [OPCODE_W-1:0]   opcode,
  output logic [CTRL_W-1:0]     control_EX,
  output logic [REG_ADDR_W-1:0] addrRT_out,
  output logic                  valid_EX
);

  logic                  rrr;
  logic [REG_ADDR_W-1:0] src_ra;
  logic [REG_ADDR_W-1:0] src_rb;
  logic [REG_ADDR_W-1:0] src_rc;
  logic [DATA_W-1:0]     rf_ra;
  logic [DATA_W-1:0]     rf_rb;
  logic [DATA_W-1:0]     rf_rc;
  rfex_t                 nxt;
  rfex_t                 pipe;

  // RA/RB sit in the same bit positions for both formats; RC shares [6:0]
  // with the RR-format RT field and is only meaningful for RRR.
  assign src_ra = instr_ID[13:7];
  assign src_rb = instr_ID[20:14];
  assign src_rc = instr_ID[6:0];

  spu_regfile #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (REG_ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (regWr_WB),
    .wr_addr   (addrRT_WB),
    .wr_data   (writeData_WB),
    .rd_addr_a (src_ra),
    .rd_addr_b (src_rb),
    .rd_addr_c (src_rc),
    .rd_data_a (rf_ra),
    .rd_data_b (rf_rb),
    .rd_data_c (rf_rc)
  );

  always_comb begin
    nxt   = '0;
    rrr   = is_rrr(instr_ID[31:28]);

    nxt.valid               = 1'b1;
    nxt.opcode              = rrr ? {instr_ID[31:28], 7'b0} : instr_ID[31:21];
    nxt.control[CTRL_RRR]   = rrr;
    nxt.control[CTRL_WR_RT] = 1'b1;
    nxt.addr_rt             = rrr ? instr_ID[27:21] : instr_ID[6:0];

    nxt.ra = select_operand(src_ra, rf_ra, regWr_EX, addrRT_EX, result_EX,
                            regWr_WB, addrRT_WB, writeData_WB);
    nxt.rb = select_operand(src_rb, rf_rb, regWr_EX, addrRT_EX, result_EX,
                            regWr_WB, addrRT_WB, writeData_WB);
    nxt.rc = rrr ? select_operand(src_rc, rf_rc, regWr_EX, addrRT_EX, result_EX,
                                  regWr_WB, addrRT_WB, writeData_WB)
                 : '0;
  end

  // Flush beats stall; a bubble (valid_ID = 0) loads an all-zero record.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe <= '0;
    end else if (flush) begin
      pipe <= '0;
    end else if (!stall) begin
      pipe <= valid_ID ? nxt : '0;
    end
  end

  assign readDataRA_EX = pipe.ra;
  assign readDataRB_EX = pipe.rb;
  assign readDataRC_EX = pipe.rc;
  assign opcode        = pipe.opcode;
  assign control_EX    = pipe.control;
  assign addrRT_out    = pipe.addr_rt;
  assign valid_EX      = pipe.valid;

endmodule
